// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC-16-CCITT constants, scheduler state type and helper functions
package crc_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam int          PAYLOAD_W  = 24;
  localparam int          CRC_W      = 16;

  typedef enum logic [1:0] {CS_IDLE, CS_SHIFT, CS_OUT} crc_sched_state_t;

  // One MSB-first LFSR step: feedback is the incoming bit xor the outgoing MSB.
  function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc,
                                                  input logic             din);
    logic fb;
    fb = din ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
  endfunction

  // Reference CRC of a whole payload, init 0, no final xor.
  function automatic logic [CRC_W-1:0] crc16_ccitt24(input logic [PAYLOAD_W-1:0] payload);
    logic [CRC_W-1:0] crc;
    crc = '0;
    for (int i = PAYLOAD_W - 1; i >= 0; i--) begin
      crc = crc16_step(crc, payload[i]);
    end
    return crc;
  endfunction

endpackage

// File: rtl/crc16_serial_core.sv
// rtl/crc16_serial_core.sv - bit-serial CRC-16-CCITT LFSR, one payload bit per enabled cycle
module crc16_serial_core
  import crc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;

  // Next LFSR value: clear wins over shift so a new frame always starts from zero.
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = crc16_step(crc_q, din);
    end
  end

  // LFSR register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/crc_frame_scheduler.sv
// rtl/crc_frame_scheduler.sv - round-robin sharing of one serial CRC engine; optional CRC_SELFCHECK_EN
module crc_frame_scheduler
  import crc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic [CRC_W-1:0]             out_crc,
  output logic [ID_W-1:0]              out_id,
  output logic                         busy
`ifdef CRC_SELFCHECK_EN
  ,
  output logic                         crc_err
`endif
);

  localparam int CNT_W = $clog2(PAYLOAD_W);

  crc_sched_state_t       state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [ID_W-1:0]        rr_q, rr_d;

  logic                   grant_vld;
  logic [ID_W-1:0]        grant_idx;
  logic                   core_clr;
  logic                   core_en;
  logic                   core_din;
  logic [CRC_W-1:0]       core_crc;

  // Round-robin pick: first valid requester at or above the pointer, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  assign core_din = payload_q[cnt_q];

  // Frame FSM: grant and latch in IDLE, 24 LFSR steps in SHIFT, hold result in OUT.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    payload_d = payload_q;
    id_d      = id_q;
    rr_d      = rr_q;
    req_ready = '0;
    core_clr  = 1'b0;
    core_en   = 1'b0;
    unique case (state_q)
      CS_IDLE: begin
        if (grant_vld) begin
          req_ready[grant_idx] = 1'b1;
          payload_d = req_payload[PAYLOAD_W*grant_idx +: PAYLOAD_W];
          id_d      = grant_idx;
          cnt_d     = CNT_W'(PAYLOAD_W - 1);
          core_clr  = 1'b1;
          rr_d      = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
          state_d   = CS_SHIFT;
        end
      end
      CS_SHIFT: begin
        core_en = 1'b1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = CS_OUT;
      end
      CS_OUT: begin
        if (out_ready) state_d = CS_IDLE;
      end
      default: state_d = CS_IDLE;
    endcase
  end

  // State, counter, latched frame and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CS_IDLE;
      cnt_q     <= '0;
      payload_q <= '0;
      id_q      <= '0;
      rr_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      payload_q <= payload_d;
      id_q      <= id_d;
      rr_q      <= rr_d;
    end
  end

  crc16_serial_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (core_clr),
    .en    (core_en),
    .din   (core_din),
    .crc   (core_crc)
  );

  assign out_valid   = (state_q == CS_OUT);
  assign busy        = (state_q != CS_IDLE);
  assign out_payload = payload_q;
  assign out_crc     = core_crc;
  assign out_id      = id_q;

`ifdef CRC_SELFCHECK_EN
  logic crc_err_q, crc_err_d;

  // The final serial CRC is predicted from the last step so the flag is valid on the first OUT cycle.
  always_comb begin
    crc_err_d = 1'b0;
    if (state_q == CS_SHIFT && cnt_q == '0) begin
      crc_err_d = (crc16_step(core_crc, core_din) != crc16_ccitt24(payload_q));
    end else if (state_q == CS_OUT && state_d == CS_OUT) begin
      crc_err_d = crc_err_q;
    end
  end

  // Error flag register, cleared when OUT is left.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_err_q <= 1'b0;
    end else begin
      crc_err_q <= crc_err_d;
    end
  end

  assign crc_err = crc_err_q;
`endif

endmodule

// File: tb/tb_crc_frame_scheduler.sv
// tb/tb_crc_frame_scheduler.sv - directed self-checking bench for crc_frame_scheduler
module tb_crc_frame_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [95:0] req_payload;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_payload;
  logic [15:0] out_crc;
  logic [1:0]  out_id;
  logic        busy;
`ifdef CRC_SELFCHECK_EN
  logic        crc_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  crc_frame_scheduler #(.NUM_REQ(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_payload (req_payload),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .out_crc     (out_crc),
    .out_id      (out_id),
    .busy        (busy)
`ifdef CRC_SELFCHECK_EN
    ,
    .crc_err     (crc_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] model_crc(input logic [23:0] p);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = 23; i >= 0; i--) begin
      fb = p[i] ^ c[15];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic run_frame(input int r, input logic [23:0] p, input logic [15:0] ec, input string tag);
    int n;
    req_valid = 4'b0000;
    req_valid[r] = 1'b1;
    req_payload[24*r +: 24] = p;
    #1;
    check({tag, ".ready"}, {28'd0, req_ready}, 32'd1 << r);
    tick();
    req_valid = 4'b0000;
    req_payload[24*r +: 24] = ~p;
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, n, 25);
    check({tag, ".payload"}, {8'd0, out_payload}, {8'd0, p});
    check({tag, ".crc"}, {16'd0, out_crc}, {16'd0, ec});
    check({tag, ".id"}, {30'd0, out_id}, r);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, {31'd0, out_valid}, 0);
  endtask

  initial begin
    int   gid[5];
    int   gcyc[5];
    int   ng;
    int   cyc;
    int   n;
    int   r;
    int   seen;
    logic [23:0] p;

    rst_n       = 1'b0;
    req_valid   = 4'b0000;
    req_payload = '0;
    out_ready   = 1'b0;
    tick();
    tick();
    check("rst.out_valid", {31'd0, out_valid}, 0);
    check("rst.busy", {31'd0, busy}, 0);
    check("rst.req_ready", {28'd0, req_ready}, 0);
    check("rst.payload", {8'd0, out_payload}, 0);
    check("rst.crc", {16'd0, out_crc}, 0);
    check("rst.id", {30'd0, out_id}, 0);
    rst_n = 1'b1;
    tick();

    run_frame(0, 24'h000001, 16'h1021, "t1");
    run_frame(0, 24'h000002, 16'h2042, "t2a");
    run_frame(1, 24'h000000, 16'h0000, "t2b");
    run_frame(2, 24'h000010, 16'h1231, "t2c");
    run_frame(3, 24'h000003, 16'h3063, "t2d");

    for (int i = 0; i < 1000; i++) begin
      p = 24'($urandom);
      r = $urandom_range(3);
      run_frame(r, p, model_crc(p), "rand");
    end

    do_reset();
    req_payload = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
    req_valid   = 4'b1111;
    out_ready   = 1'b1;
    #1;
    ng  = 0;
    cyc = 0;
    while (ng < 5 && cyc < 300) begin
      if (req_ready != 4'b0000) begin
        check("rr.onehot", $countones(req_ready), 1);
        for (int b = 0; b < 4; b++) if (req_ready[b]) gid[ng] = b;
        gcyc[ng] = cyc;
        ng++;
      end
      tick();
      cyc++;
    end
    check("rr.grants", ng, 5);
    for (int i = 0; i < 5; i++) begin
      if (i < ng) check("rr.order", gid[i], i % 4);
      if (i > 0 && i < ng) check("rr.spacing", gcyc[i] - gcyc[i-1], 26);
    end
    req_valid = 4'b0000;
    out_ready = 1'b0;

    do_reset();
    req_payload[24 +: 24] = 24'h000003;
    req_valid = 4'b0010;
    #1;
    check("hold.grant1", {28'd0, req_ready}, 4'b0010);
    tick();
    req_payload[0 +: 24] = 24'h000001;
    req_valid = 4'b0001;
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("hold.latency", n, 25);
    for (int i = 0; i < 10; i++) begin
      check("hold.valid", {31'd0, out_valid}, 1);
      check("hold.crc", {16'd0, out_crc}, 32'h3063);
      check("hold.payload", {8'd0, out_payload}, 32'h000003);
      check("hold.id", {30'd0, out_id}, 1);
      check("hold.no_ready", {28'd0, req_ready}, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("hold.hs_no_ready", {28'd0, req_ready}, 0);
    tick();
    out_ready = 1'b0;
    check("hold.valid_drop", {31'd0, out_valid}, 0);
    check("hold.next_grant", {28'd0, req_ready}, 4'b0001);
    tick();
    req_valid = 4'b0000;

    do_reset();
    req_payload[48 +: 24] = 24'hABCDEF;
    req_valid = 4'b0100;
    #1;
    check("mrst.grant2", {28'd0, req_ready}, 4'b0100);
    tick();
    req_valid = 4'b0000;
    for (int i = 0; i < 11; i++) tick();
    check("mrst.busy_before", {31'd0, busy}, 1);
    rst_n = 1'b0;
    tick();
    check("mrst.out_valid", {31'd0, out_valid}, 0);
    check("mrst.busy", {31'd0, busy}, 0);
    check("mrst.payload", {8'd0, out_payload}, 0);
    check("mrst.crc", {16'd0, out_crc}, 0);
    check("mrst.id", {30'd0, out_id}, 0);
    check("mrst.req_ready", {28'd0, req_ready}, 0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("mrst.no_frame", seen, 0);
    req_valid = 4'b1111;
    #1;
    check("mrst.rr_zero", {28'd0, req_ready}, 4'b0001);
    tick();
    req_valid = 4'b0000;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
